// File: rtl/game_pkg.sv
// Shared types and helpers for the asteroid game blocks: coordinate widths,
// the destroy-event FSM state encoding and the per-axis box test.
package game_pkg;

    localparam int COORD_W = 10;
    localparam int EXPL_W  = 33;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD, SCAN_H} state_e;

    // Differences are taken one bit wider than the coordinates so they never wrap.
    function automatic logic abs_diff_le(input logic [COORD_W-1:0] a,
                                         input logic [COORD_W-1:0] b,
                                         input logic [COORD_W:0]   r);
        logic signed [COORD_W:0] d;
        logic        [COORD_W:0] m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = d[COORD_W] ? $unsigned(-d) : $unsigned(d);
        return m <= r;
    endfunction

endpackage

// File: rtl/hit_compare.sv
// Combinational bullet-vs-asteroid box test for one slot.
module hit_compare
    import game_pkg::*;
#(
    parameter int HIT_RADIUS = 20
) (
    input  logic [COORD_W-1:0] bh_i,
    input  logic [COORD_W-1:0] bv_i,
    input  logic [COORD_W-1:0] ah_i,
    input  logic [COORD_W-1:0] av_i,
    input  logic               alive_i,
    output logic               hit_o
);

    localparam logic [COORD_W:0] R = HIT_RADIUS[COORD_W:0];

    assign hit_o = alive_i & abs_diff_le(bh_i, ah_i, R) & abs_diff_le(bv_i, av_i, R);

endmodule

// File: rtl/destroy_event_gen.sv
// Per-frame collision scanner driving the explosion renderer (destroy/dH/dV).
// Define DESTROY_RETRIGGER_EN to allow new hits to be scanned while an explosion is shown.
module destroy_event_gen
    import game_pkg::*;
#(
    parameter int NUM_AST     = 8,
    parameter int HIT_RADIUS  = 20,
    parameter int ANIM_FRAMES = 30
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       frameTick,
    input  logic                       bulletValid,
    input  logic [COORD_W-1:0]         bH,
    input  logic [COORD_W-1:0]         bV,
    input  logic [COORD_W*NUM_AST-1:0] astH,
    input  logic [COORD_W*NUM_AST-1:0] astV,
    input  logic [NUM_AST-1:0]         astAlive,
    output logic [NUM_AST-1:0]         astKill,
    output logic                       bulletKill,
    output logic                       destroy,
    output logic [EXPL_W-1:0]          dH,
    output logic [EXPL_W-1:0]          dV,
    output logic                       busy
);

    localparam int                 IDX_W    = (NUM_AST > 1) ? $clog2(NUM_AST) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_AST - 1);
    localparam logic [7:0]         ANIM     = 8'(ANIM_FRAMES);

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [7:0]           frame_cnt_q;
    logic [NUM_AST-1:0]   ast_kill_q;
    logic                 bullet_kill_q;
    logic                 destroy_q;
    logic [EXPL_W-1:0]    dh_q;
    logic [EXPL_W-1:0]    dv_q;

    logic [COORD_W-1:0]   cur_h;
    logic [COORD_W-1:0]   cur_v;
    logic                 cur_alive;
    logic                 hit;

    // A single comparator is time-shared across slots by the scan index.
    assign cur_h     = astH[idx_q*COORD_W +: COORD_W];
    assign cur_v     = astV[idx_q*COORD_W +: COORD_W];
    assign cur_alive = astAlive[idx_q];

    hit_compare #(.HIT_RADIUS(HIT_RADIUS)) u_hit (
        .bh_i    (bH),
        .bv_i    (bV),
        .ah_i    (cur_h),
        .av_i    (cur_v),
        .alive_i (cur_alive),
        .hit_o   (hit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            ast_kill_q    <= '0;
            bullet_kill_q <= 1'b0;
            destroy_q     <= 1'b0;
            dh_q          <= '0;
            dv_q          <= '0;
        end else begin
            ast_kill_q    <= '0;
            bullet_kill_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frameTick && bulletValid) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                    end
                end
                SCAN, SCAN_H: begin
                    // A scan launched from HOLD falls back to HOLD, not IDLE.
                    if (!bulletValid) begin
                        state_q <= (state_q == SCAN_H) ? HOLD : IDLE;
                    end else if (hit) begin
                        ast_kill_q    <= NUM_AST'(1) << idx_q;
                        bullet_kill_q <= 1'b1;
                        dh_q          <= EXPL_W'(cur_h);
                        dv_q          <= EXPL_W'(cur_v);
                        destroy_q     <= 1'b1;
                        frame_cnt_q   <= ANIM;
                        state_q       <= HOLD;
                    end else if (idx_q == LAST_IDX) begin
                        state_q <= (state_q == SCAN_H) ? HOLD : IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (frameTick) begin
                        frame_cnt_q <= frame_cnt_q - 8'd1;
                        if (frame_cnt_q == 8'd1) begin
                            destroy_q <= 1'b0;
                            state_q   <= IDLE;
                        end
`ifdef DESTROY_RETRIGGER_EN
                        else if (bulletValid) begin
                            state_q <= SCAN_H;
                            idx_q   <= '0;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign astKill    = ast_kill_q;
    assign bulletKill = bullet_kill_q;
    assign destroy    = destroy_q;
    assign dH         = dh_q;
    assign dV         = dv_q;
    assign busy       = (state_q != IDLE);

endmodule
